// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with a small transmit FIFO.
// The serial line is registered and changes together with the frame FSM state.

module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [LW-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is flushed logically by the pointer reset; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

module uart_tx_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUDRATE   = 2000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int DIV = CLK_HZ / BAUDRATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_tx_core: CLK_HZ/BAUDRATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_tx_core: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    head;
  logic          push, pop, baud_end, fifo_empty;

  assign fifo_empty = (fifo_level == '0);
  assign tx_ready   = (fifo_level < FULL_LVL);
  assign push       = tx_valid && tx_ready;
  assign baud_end   = (baud_cnt == BAUD_LAST);
  // Pop only from registered level, so a byte pushed this cycle is never bypassed.
  assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && baud_end));
  assign busy       = (state != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (tx_data),
    .pop    (pop),
    .dout   (head),
    .level  (fifo_level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            shreg   <= head;
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            uart_tx  <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shreg   <= head;
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at 50 MHz / 2 Mbaud with a loopback line monitor.

module tb_uart_tx_core;
  localparam int DIV = 25;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mq[$];
  int         ms_q[$];
  int         frame_err = 0;
  int         idle_bad = 0;
  int         lvl_bad = 0;

  uart_tx_core #(
    .CLK_HZ     (50000000),
    .BAUDRATE   (2000000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Loopback receiver: samples mid-bit, records decoded bytes and start cycles.
  initial begin : mon
    bit         active;
    int         mcnt;
    int         idx;
    logic [7:0] msh;
    active = 1'b0;
    mcnt   = 0;
    msh    = '0;
    forever begin
      @(negedge clk);
      if (busy === 1'b0 && uart_tx !== 1'b1) idle_bad++;
      if (fifo_level > 3'd4) lvl_bad++;
      if (resetn !== 1'b1) active = 1'b0;
      else if (!active) begin
        if (uart_tx === 1'b0) begin
          active = 1'b1;
          mcnt   = 0;
          ms_q.push_back(cyc);
        end
      end else mcnt++;
      if (active && (mcnt % DIV) == DIV / 2) begin
        idx = mcnt / DIV;
        if (idx == 0) begin
          if (uart_tx !== 1'b0) frame_err++;
        end else if (idx < 9) begin
          msh[idx-1] = uart_tx;
        end else begin
          if (uart_tx !== 1'b1) frame_err++;
          mq.push_back(msh);
          active = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int g;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = b;
    g = 0;
    @(negedge clk);
    while (!tx_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] b, input string tag);
    int   bad;
    logic e;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int c = 0; c < DIV; c++) begin
        if (uart_tx !== e) bad++;
        @(negedge clk);
      end
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin : stim
    int         n0, nacc, guard, mism;
    bit         took;
    int         acc[6];
    int         acc_exp[6];
    logic [7:0] seq[4];
    logic [7:0] eq[$];

    acc_exp = '{0, 1, 2, 3, 4, 252};
    seq     = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    resetn   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // Single byte 0xA5; push on the first edge after reset release
    @(posedge clk); #1;
    resetn   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    check("a5_ready", 32'(tx_ready), 32'd1);
    n0 = cyc;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("a5_level_n1", 32'(fifo_level), 32'd1);
    check("a5_line_n1", 32'(uart_tx), 32'd1);
    check("a5_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    check("a5_start_cycle", 32'(cyc - n0), 32'd2);
    check_frame(8'hA5, "a5_frame_bits");
    check("a5_busy_end", 32'(busy), 32'd0);
    check("a5_line_end", 32'(uart_tx), 32'd1);
    check("a5_mon_byte", 32'(mq.size() == 1 ? mq[0] : 8'hxx), 32'h0A5);

    // Hold tx_valid with 0x01..0x06; FIFO back-pressure and back-to-back frames
    mq.delete();
    ms_q.delete();
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    nacc  = 0;
    guard = 0;
    while (nacc < 6 && guard < 2000) begin
      @(negedge clk);
      guard++;
      took = tx_ready;
      if (took) begin
        acc[nacc] = cyc;
        nacc++;
      end
      @(posedge clk); #1;
      if (took) begin
        tx_data = 8'(nacc + 1);
        if (nacc == 6) tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    check("burst_accepts", 32'(nacc), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("burst_acc_cycle%0d", k), 32'(acc[k] - acc[0]), 32'(acc_exp[k]));
    wait_idle("burst_idle", 2000);
    check("burst_busy_fall", 32'(cyc - acc[0]), 32'd1502);
    check("burst_frames", 32'(mq.size()), 32'd6);
    mism = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < mq.size() && mq[k] !== 8'(k + 1)) mism++;
      if (k < ms_q.size() && ms_q[k] != acc[0] + 2 + 250 * k) mism++;
    end
    check("burst_order_gaps", 32'(mism), 32'd0);

    // Reset at cycle 100 of a frame with bytes still queued
    mq.delete();
    push_byte(8'h81);
    push_byte(8'h82);
    push_byte(8'h83);
    guard = 0;
    while (uart_tx !== 1'b0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (100) @(negedge clk);
    check("pre_rst_level", 32'(fifo_level), 32'd2);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_line", 32'(uart_tx), 32'd1);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_ready", 32'(tx_ready), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    check("rst_abort_no_byte", 32'(mq.size()), 32'd0);
    resetn   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("post_rst_first_push", 32'(fifo_level), 32'd1);
    wait_idle("post_rst_idle", 500);
    check("post_rst_count", 32'(mq.size()), 32'd1);
    check("post_rst_byte", 32'(mq.size() > 0 ? mq[0] : 8'hxx), 32'h03C);

    // Loopback of 00, FF, 55, AA
    mq.delete();
    for (int k = 0; k < 4; k++) push_byte(seq[k]);
    wait_idle("loop_idle", 1500);
    check("loop_count", 32'(mq.size()), 32'd4);
    mism = 0;
    for (int k = 0; k < 4; k++)
      if (k < mq.size() && mq[k] !== seq[k]) mism++;
    check("loop_order", 32'(mism), 32'd0);
    check("loop_framing", 32'(frame_err), 32'd0);

    // Random valid toggling, 200 random bytes, scoreboard in push order
    mq.delete();
    tx_valid = 1'b0;
    took  = 1'b0;
    nacc  = 0;
    guard = 0;
    while (nacc < 200 && guard < 60000) begin
      @(posedge clk); #1;
      guard++;
      if (took) begin
        tx_valid = 1'b0;
        took     = 1'b0;
      end
      if (!tx_valid && $urandom_range(0, 2) != 0) begin
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
      end
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        eq.push_back(tx_data);
        nacc++;
        took = 1'b1;
      end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_idle("rnd_idle", 2000);
    check("rnd_count", 32'(mq.size()), 32'd200);
    mism = 0;
    for (int k = 0; k < eq.size(); k++)
      if (k >= mq.size() || mq[k] !== eq[k]) mism++;
    check("rnd_order", 32'(mism), 32'd0);
    check("rnd_framing", 32'(frame_err), 32'd0);
    check("level_bound", 32'(lvl_bad), 32'd0);
    check("idle_line_high", 32'(idle_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 2000000, serial bit rate; DIV = CLK_HZ/BAUDRATE (integer truncation), DIV >= 2 required, elaborate-time error otherwise.
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, >= 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 tx_data  input  8  byte to transmit, sampled when tx_valid && tx_ready.
REQ-007 tx_valid  input  1  producer has a byte on tx_data.
REQ-008 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 uart_tx  output  1  serial line, idle high, registered output.
REQ-010 busy  output  1  FIFO non-empty or frame in progress.
REQ-011 fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly DIV clk cycles; frame = 10*DIV cycles.
REQ-013 tx_ready SHALL equal (fifo_level < FIFO_DEPTH), combinational from registered level only; never from tx_valid.
REQ-014 Push SHALL occur on any cycle with tx_valid && tx_ready; tx_valid without tx_ready SHALL be ignored, no data loss, producer holds.
REQ-015 FSM states: IDLE, START, DATA, STOP; bit counter 0..7 in DATA; baud counter 0..DIV-1 in START/DATA/STOP.
REQ-016 IDLE: if fifo_level != 0, pop head into shift register, go to START; uart_tx SHALL be low from the following cycle.
REQ-017 START -> DATA after DIV cycles; DATA -> STOP after 8*DIV cycles; shift register shifts right at each bit boundary.
REQ-018 STOP end: if fifo_level != 0, pop and go directly to START (zero idle gap between frames); else go to IDLE.
REQ-019 Push at cycle N into empty FIFO with FSM in IDLE: pop at N+1, start bit visible on uart_tx from N+2.
REQ-020 Push into empty FIFO same cycle as pop opportunity SHALL NOT bypass; the byte is popped no earlier than next cycle.
REQ-021 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve order.
REQ-022 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full = level == FIFO_DEPTH, empty = level == 0.
REQ-023 busy SHALL be 1 whenever state != IDLE or fifo_level != 0.
REQ-024 Bytes SHALL be transmitted in exact push order; no byte dropped or duplicated.

Reset
REQ-025 resetn low SHALL immediately (asynchronously) force: uart_tx=1, state=IDLE, fifo_level=0, tx_ready=1, busy=0, counters and pointers 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame, flush the FIFO; line returns high without completing the byte.
REQ-027 After resetn rises, first push accepted on the first clk edge; no extra idle period required.

Verification
REQ-028 DIV=25, push 8'hA5 once into idle core -> uart_tx low 25 cycles from N+2, then bits 1,0,1,0,0,1,0,1 each 25 cycles, high stop 25 cycles; busy falls after 250 line cycles.
REQ-029 Hold tx_valid high with 6 bytes 8'h01..8'h06 -> 5 accepted on consecutive cycles (1 in shifter, 4 in FIFO), tx_ready 0 until next pop; all 6 sent back-to-back, 6*250 cycles, no gaps.
REQ-030 Assert resetn low at cycle 100 of a frame -> uart_tx=1 same cycle, fifo_level=0, tx_ready=1; next pushed byte 8'h3C transmitted correctly.
REQ-031 Loopback uart_tx into the UART monitor at 50 MHz / 2 Mbaud, send 8'h00, 8'hFF, 8'h55, 8'hAA -> monitor decodes identical sequence, no framing errors.
REQ-032 Random tx_valid toggling, 200 random bytes -> scoreboard order match, fifo_level never exceeds FIFO_DEPTH, uart_tx never low in IDLE.
